// File: rtl/mem_access_ctrl_if.sv
// Data-memory bus between the access controller (master) and memory (slave).
// Word-addressed requests with per-byte enables; gnt accepts a request, rvalid returns read data.
`ifndef XLEN
`define XLEN 32
`endif

interface mem_access_ctrl_if;
   logic              req;
   logic              we;
   logic [`XLEN-1:0]  addr;
   logic [`XLEN-1:0]  wdata;
   logic [3:0]        be;
   logic              gnt;
   logic [`XLEN-1:0]  rdata;
   logic              rvalid;

   modport master (output req, we, addr, wdata, be, input gnt, rdata, rvalid);
   modport slave  (input req, we, addr, wdata, be, output gnt, rdata, rvalid);
endinterface

// File: rtl/mem_access_ctrl.sv
// MEM-stage access sequencer: drives one EX/MEM load/store onto the bus and stalls the pipe until done.
// Optional MISALIGN_TRAP_EN: misaligned H/W accesses abort with err instead of using the aligned word.
`ifndef XLEN
`define XLEN 32
`endif

module mem_access_ctrl #(
   parameter int unsigned TIMEOUT = 16,
   parameter int unsigned TO_W    = 5
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              mem_read_i,
   input  logic              mem_write_i,
   input  logic [2:0]        mem_mode_i,
   input  logic [`XLEN-1:0]  addr_i,
   input  logic [`XLEN-1:0]  wdata_i,
   output logic              stall_o,
   output logic [`XLEN-1:0]  load_data_o,
   output logic              load_valid_o,
   output logic              err_o,
   mem_access_ctrl_if.master bus
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic [1:0]        state_q, state_d;
   logic [`XLEN-1:0]  addr_q, addr_d;
   logic [`XLEN-1:0]  wdata_q, wdata_d;
   logic [2:0]        mode_q, mode_d;
   logic              we_q, we_d;
   logic              rd_q, rd_d;
   logic              err_q, err_d;
   logic [TO_W-1:0]   cnt_q, cnt_d;
   logic [`XLEN-1:0]  ld_q, ld_d;

   logic              access, both, illegal, misal, to_hit;
   logic [TO_W-1:0]   cnt_inc;
   logic [3:0]        be;
   logic [`XLEN-1:0]  st_data, ld_fmt, ld_sh;

   assign access  = mem_read_i ^ mem_write_i;
   assign both    = mem_read_i & mem_write_i;
   assign illegal = (mem_mode_i == 3'b011) || (mem_mode_i == 3'b110) || (mem_mode_i == 3'b111);
`ifdef MISALIGN_TRAP_EN
   assign misal   = ((mem_mode_i[1:0] == 2'b01) && addr_i[0]) ||
                    ((mem_mode_i[1:0] == 2'b10) && (addr_i[1:0] != 2'b00));
`else
   assign misal   = 1'b0;
`endif

   // Saturate so a grant on the very last REQ cycle cannot wrap the counter in WAIT.
   assign cnt_inc = (cnt_q == {TO_W{1'b1}}) ? cnt_q : cnt_q + TO_W'(1);
   assign to_hit  = (TIMEOUT != 0) && (32'(cnt_inc) >= TIMEOUT);

   always_comb begin
      be      = 4'b1111;
      st_data = wdata_q;
      case (mode_q[1:0])
         2'b00: begin
            be      = 4'b0001 << addr_q[1:0];
            st_data = {4{wdata_q[7:0]}};
         end
         2'b01: begin
            be      = addr_q[1] ? 4'b1100 : 4'b0011;
            st_data = {2{wdata_q[15:0]}};
         end
         default: ;
      endcase
   end

   always_comb begin
      ld_sh  = bus.rdata >> {addr_q[1:0], 3'b000};
      ld_fmt = bus.rdata;
      case (mode_q[1:0])
         2'b00:   ld_fmt = {{24{ld_sh[7] & ~mode_q[2]}}, ld_sh[7:0]};
         2'b01:   ld_fmt = addr_q[1] ? {{16{bus.rdata[31] & ~mode_q[2]}}, bus.rdata[31:16]}
                                     : {{16{bus.rdata[15] & ~mode_q[2]}}, bus.rdata[15:0]};
         default: ;
      endcase
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      mode_d  = mode_q;
      we_d    = we_q;
      rd_d    = rd_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      ld_d    = ld_q;
      case (state_q)
         S_IDLE: begin
            if (both || (access && (illegal || misal))) begin
               state_d = S_DONE;
               err_d   = 1'b1;
               rd_d    = 1'b0;
               ld_d    = '0;
            end else if (access) begin
               state_d = S_REQ;
               addr_d  = addr_i;
               wdata_d = wdata_i;
               mode_d  = mem_mode_i;
               we_d    = mem_write_i;
               rd_d    = mem_read_i;
               err_d   = 1'b0;
               cnt_d   = '0;
            end
         end
         S_REQ: begin
            cnt_d = cnt_inc;
            if (bus.gnt) begin
               state_d = we_q ? S_DONE : S_WAIT;
            end else if (to_hit) begin
               state_d = S_DONE;
               err_d   = 1'b1;
               ld_d    = '0;
            end
         end
         S_WAIT: begin
            cnt_d = cnt_inc;
            if (bus.rvalid) begin
               state_d = S_DONE;
               ld_d    = ld_fmt;
            end else if (to_hit) begin
               state_d = S_DONE;
               err_d   = 1'b1;
               ld_d    = '0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         mode_q  <= '0;
         we_q    <= 1'b0;
         rd_q    <= 1'b0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
         ld_q    <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         mode_q  <= mode_d;
         we_q    <= we_d;
         rd_q    <= rd_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
         ld_q    <= ld_d;
      end
   end

   // An early-error access also holds the pipe for its IDLE cycle so the err pulse lines up with it.
   assign stall_o      = ((state_q == S_IDLE) && (mem_read_i || mem_write_i)) ||
                         (state_q == S_REQ) || (state_q == S_WAIT);
   assign load_data_o  = ld_q;
   assign load_valid_o = (state_q == S_DONE) && rd_q && !err_q;
   assign err_o        = (state_q == S_DONE) && err_q;

   assign bus.req   = (state_q == S_REQ);
   assign bus.we    = (state_q == S_REQ) && we_q;
   assign bus.addr  = {addr_q[`XLEN-1:2], 2'b00};
   assign bus.wdata = st_data;
   assign bus.be    = (state_q == S_REQ) ? be : 4'b0000;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized bench for mem_access_ctrl: a per-transaction timeline model predicts stall, bus and result per cycle.
`timescale 1ns/1ps
module tb_mem_access_ctrl;
   localparam int TIMEOUT = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_read, mem_write;
   logic [2:0]  mem_mode;
   logic [31:0] addr, wdata;
   logic        stall, load_valid, err;
   logic [31:0] load_data;
   int          n_tests = 0;
   int          n_fail  = 0;

   mem_access_ctrl_if bus();

   mem_access_ctrl #(.TIMEOUT(TIMEOUT), .TO_W(5)) dut (
      .clk_i(clk), .rst_i(rst),
      .mem_read_i(mem_read), .mem_write_i(mem_write), .mem_mode_i(mem_mode),
      .addr_i(addr), .wdata_i(wdata),
      .stall_o(stall), .load_data_o(load_data), .load_valid_o(load_valid), .err_o(err),
      .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] exp_load(input logic [2:0] mode, input logic [31:0] a, input logic [31:0] d);
      int unsigned b, h;
      b = (d >> (8 * a[1:0])) & 32'hFF;
      h = (d >> (a[1] ? 16 : 0)) & 32'hFFFF;
      case (mode)
         3'b000:  return (b >= 128) ? b + 32'hFFFFFF00 : b;
         3'b100:  return b;
         3'b001:  return (h >= 32768) ? h + 32'hFFFF0000 : h;
         3'b101:  return h;
         default: return d;
      endcase
   endfunction

   function automatic bit is_misal(input logic [2:0] mode, input logic [31:0] a);
`ifdef MISALIGN_TRAP_EN
      return ((mode[1:0] == 2'b01) && a[0]) || ((mode[1:0] == 2'b10) && (a[1:0] != 2'b00));
`else
      return 1'b0;
`endif
   endfunction

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         mem_read = 0; mem_write = 0;
         bus.gnt = 1'($urandom); bus.rvalid = 1'($urandom); bus.rdata = $urandom;
         #1;
         chk("idle_stall", {31'b0, stall}, 0);
         chk("idle_req", {31'b0, bus.req}, 0);
         chk("idle_lv", {31'b0, load_valid}, 0);
         chk("idle_err", {31'b0, err}, 0);
      end
   endtask

   // g: REQ cycle carrying gnt (0 = never); r: WAIT cycle carrying rvalid (0 = never)
   task automatic run_acc(input bit rd, input bit wr, input logic [2:0] mode, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rdat, input int g, input int r);
      bit early, is_rd, to, exp_req, real_rv;
      int last, req_end;
      logic [3:0] e_be;
      logic [31:0] e_wd;
      is_rd = rd && !wr;
      early = (rd && wr) || mode == 3'b011 || mode == 3'b110 || mode == 3'b111 || is_misal(mode, a);
      to    = !early && (g == 0 || (is_rd && r == 0));
      last  = early ? 1 : to ? TIMEOUT + 1 : is_rd ? g + r + 1 : g + 1;
      req_end = early ? 0 : (g == 0) ? TIMEOUT : g;
      case (mode[1:0])
         2'b00:   begin e_be = 4'(1 << a[1:0]); e_wd = (wd & 32'hFF) * 32'h01010101; end
         2'b01:   begin e_be = a[1] ? 4'hC : 4'h3; e_wd = (wd & 32'hFFFF) * 32'h00010001; end
         default: begin e_be = 4'hF; e_wd = wd; end
      endcase
      for (int k = 0; k <= last; k++) begin
         @(negedge clk);
         mem_read = rd; mem_write = wr; mem_mode = mode; addr = a; wdata = wd;
         real_rv    = is_rd && !early && g != 0 && r != 0 && k == g + r;
         bus.gnt    = (!early && g != 0 && k == g) ? 1'b1 : (g != 0 && k > g) ? 1'($urandom) : 1'b0;
         bus.rvalid = real_rv ? 1'b1 : (k <= g || k == last) ? 1'($urandom) : 1'b0;
         bus.rdata  = real_rv ? rdat : $urandom;
         #1;
         exp_req = (k >= 1 && k <= req_end);
         chk("stall", {31'b0, stall}, {31'b0, k < last});
         chk("bus_req", {31'b0, bus.req}, {31'b0, exp_req});
         if (exp_req && k == 1) begin
            chk("bus_addr", bus.addr, {a[31:2], 2'b00});
            chk("bus_we", {31'b0, bus.we}, {31'b0, wr});
            chk("bus_be", {28'b0, bus.be}, {28'b0, e_be});
            if (wr) chk("bus_wdata", bus.wdata, e_wd);
         end
         chk("err", {31'b0, err}, {31'b0, (k == last) && (early || to)});
         chk("load_valid", {31'b0, load_valid}, {31'b0, (k == last) && is_rd && !early && !to});
         if (k == last && is_rd && !early && !to) chk("load_data", load_data, exp_load(mode, a, rdat));
         if (k == last && to) chk("to_load_data", load_data, 0);
      end
   endtask

   initial begin
      rst = 1; mem_read = 0; mem_write = 0; mem_mode = 0; addr = 0; wdata = 0;
      bus.gnt = 0; bus.rvalid = 0; bus.rdata = 0;
      repeat (3) @(posedge clk);
      @(negedge clk); #1;
      chk("rst_stall", {31'b0, stall}, 0);
      chk("rst_lv", {31'b0, load_valid}, 0);
      chk("rst_err", {31'b0, err}, 0);
      chk("rst_ld", load_data, 0);
      chk("rst_req", {31'b0, bus.req}, 0);
      chk("rst_we", {31'b0, bus.we}, 0);
      chk("rst_be", {28'b0, bus.be}, 0);
      rst = 0;
      idle(1);

      run_acc(0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 1, 0);
      run_acc(0, 1, 3'b000, 32'h103, 32'h000000A5, 32'h0, 2, 0);
      run_acc(1, 0, 3'b000, 32'h102, 32'h0, 32'h12F45678, 1, 2);
      run_acc(1, 0, 3'b101, 32'h102, 32'h0, 32'h80011234, 1, 1);
      run_acc(1, 0, 3'b001, 32'h102, 32'h0, 32'h80011234, 2, 1);
      run_acc(0, 1, 3'b001, 32'h202, 32'h0000BEEF, 32'h0, 1, 0);
      run_acc(1, 0, 3'b010, 32'h300, 32'h0, 32'h0, 0, 0);
      run_acc(1, 0, 3'b010, 32'h101, 32'h0, 32'hCAFEF00D, 1, 1);
      run_acc(1, 0, 3'b010, 32'h400, 32'h0, 32'h0, 3, 0);
      run_acc(1, 1, 3'b010, 32'h500, 32'h0, 32'h0, 1, 1);
      run_acc(1, 0, 3'b111, 32'h600, 32'h0, 32'h0, 1, 1);
      run_acc(0, 1, 3'b011, 32'h604, 32'h1, 32'h0, 1, 0);
      idle(2);

      // reset while a request is outstanding; a late rvalid must not surface
      @(negedge clk);
      mem_read = 1; mem_write = 0; mem_mode = 3'b010; addr = 32'h700; bus.gnt = 0; bus.rvalid = 0;
      @(negedge clk); #1;
      chk("mid_req", {31'b0, bus.req}, 1);
      rst = 1; mem_read = 0;
      @(negedge clk);
      rst = 0; bus.rvalid = 1; bus.rdata = 32'h55AA55AA;
      #1;
      chk("mid_rst_req", {31'b0, bus.req}, 0);
      chk("mid_rst_stall", {31'b0, stall}, 0);
      @(negedge clk); bus.rvalid = 0; #1;
      chk("mid_rst_lv", {31'b0, load_valid}, 0);
      chk("mid_rst_err", {31'b0, err}, 0);

      for (int i = 0; i < 60; i++) begin
         int kind;
         logic [2:0] m;
         kind = $urandom_range(0, 9);
         if (kind == 0) begin
            case ($urandom_range(0, 2))
               0: m = 3'b011;
               1: m = 3'b110;
               default: m = 3'b111;
            endcase
            run_acc(1'($urandom), 1'b1 ^ 1'($urandom & 0), m, $urandom, $urandom, $urandom, 1, 1);
         end else if (kind == 1) begin
            run_acc(1, 1, 3'b000, $urandom, $urandom, $urandom, 1, 1);
         end else if (kind < 6) begin
            case ($urandom_range(0, 4))
               0: m = 3'b000;
               1: m = 3'b001;
               2: m = 3'b010;
               3: m = 3'b100;
               default: m = 3'b101;
            endcase
            run_acc(1, 0, m, $urandom, $urandom, $urandom, $urandom_range(1, 5), $urandom_range(1, 5));
         end else begin
            m = 3'($urandom_range(0, 2));
            run_acc(0, 1, m, $urandom, $urandom, $urandom, $urandom_range(1, 5), 0);
         end
         if ($urandom_range(0, 3) == 0) idle(1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
